tpu_nxn: RTL

Parametrised successor of the fixed 2x2 TPU top. It computes a signed N x N matrix product C = A x W on a weight-stationary systolic grid. Operands are loaded byte-serially through `ui_in` using fetch flags, and results are streamed out row-major on `wire_out`. Over the 2x2 design it adds an N parameter, a multi-run accumulate mode, a ReLU mode, output saturation and an explicit output handshake.

---
 rtl/tpu_nxn.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tpu_nxn.sv
// tpu_nxn: signed N x N matrix product C = A x W on a weight-stationary
// systolic grid, with optional accumulation into the previous result,
// output saturation to DATA_W and optional ReLU.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   ui_in      serial operand byte (signed DATA_W)
//   fetch_w    write ui_in into the weight buffer (IDLE only, wins over fetch_inp)
//   fetch_inp  write ui_in into the input buffer (IDLE only)
//   start      begin a run (IDLE only); latches acc_mode and relu_en
//   acc_mode   1 = add this product to the previous result, 0 = fresh result
//   relu_en    1 = clamp negative output elements to 0
//   wire_out   result element, row-major, 0 when out_valid is low
//   out_valid  wire_out holds a valid element (N*N consecutive cycles)
//   busy       high through COMPUTE and OUTPUT
//   done       one-cycle pulse after the last element
module tpu_nxn #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ui_in,
    input  logic              fetch_w,
    input  logic              fetch_inp,
    input  logic              start,
    input  logic              acc_mode,
    input  logic              relu_en,
    output logic [DATA_W-1:0] wire_out,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int NN     = N * N;
    localparam int PTR_W  = (NN > 1) ? $clog2(NN) : 1;
    localparam int CNT_W  = $clog2(3 * N);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(3 * N - 2);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] i_ptr;
    logic [PTR_W-1:0] out_idx;
    logic [CNT_W-1:0] cnt;
    logic             acc_l;
    logic             relu_l;

    // Operand buffers and result accumulators, flat row-major.
    logic signed [DATA_W-1:0] w_buf [NN];
    logic signed [DATA_W-1:0] a_buf [NN];
    logic signed [ACC_W-1:0]  r_buf [NN];

    // Grid: activations move right along row k, partial sums move down column j.
    logic signed [DATA_W-1:0] feed    [N];
    logic signed [DATA_W-1:0] a_in    [N][N];
    logic signed [ACC_W-1:0]  s_in    [N][N];
    logic signed [PROD_W-1:0] prod    [N][N];
    logic signed [DATA_W-1:0] act_p1  [N][N];
    logic signed [ACC_W-1:0]  psum_p1 [N][N];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Clamp a one-bit-wider sum back into the signed ACC_W range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        if (v[SUM_W-1] != v[SUM_W-2])
            sat_acc = v[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sat_acc = v[ACC_W-1:0];
    endfunction

    // Clamp an accumulator value into the signed DATA_W range.
    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-DATA_W:0] hi;
        hi = v[ACC_W-1:DATA_W-1];
        if ((&hi) || (~|hi))
            sat_out = v[DATA_W-1:0];
        else if (v[ACC_W-1])
            sat_out = {1'b1, {(DATA_W-1){1'b0}}};
        else
            sat_out = {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v,
                                                      input logic en);
        relu = (en && v[DATA_W-1]) ? '0 : v;
    endfunction

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_COMPUTE;
            S_COMPUTE: if (cnt == CNT_LAST) state_nxt = S_OUTPUT;
            S_OUTPUT:  if (out_idx == PTR_LAST) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        busy      = (state == S_COMPUTE) || (state == S_OUTPUT);
        done      = (state == S_DONE);
        out_valid = (state == S_OUTPUT);
        wire_out  = '0;
        if (state == S_OUTPUT)
            wire_out = relu(sat_out(r_buf[out_idx]), relu_l);
    end

    // Control: load pointers, phase counters and latched run modes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr   <= '0;
            i_ptr   <= '0;
            cnt     <= '0;
            out_idx <= '0;
            acc_l   <= 1'b0;
            relu_l  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_w)
                        w_ptr <= ptr_inc(w_ptr);
                    else if (fetch_inp)
                        i_ptr <= ptr_inc(i_ptr);
                    if (start) begin
                        acc_l  <= acc_mode;
                        relu_l <= relu_en;
                    end
                    cnt     <= '0;
                    out_idx <= '0;
                end
                S_COMPUTE: cnt <= cnt + CNT_W'(1);
                S_OUTPUT: begin
                    out_idx <= out_idx + PTR_W'(1);
                    // Pointers restart on the way into DONE so the next load begins at [0][0].
                    if (out_idx == PTR_LAST) begin
                        w_ptr <= '0;
                        i_ptr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand buffers; writes only while idle, weight write has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < NN; e++) begin
                w_buf[e] <= '0;
                a_buf[e] <= '0;
            end
        end else if (state == S_IDLE) begin
            if (fetch_w)
                w_buf[w_ptr] <= ui_in;
            else if (fetch_inp)
                a_buf[i_ptr] <= ui_in;
        end
    end

    // ---------------- stage p0: skewed feed and PE combinational ----------------
    // Row k receives A[i][k] in compute cycle i+k; zeros outside the window
    // flush the grid so it is all-zero again at the end of every run.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            feed[k] = '0;
            for (int i = 0; i < N; i++)
                if ((state == S_COMPUTE) && (int'(cnt) == i + k))
                    feed[k] = a_buf[i * N + k];
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                a_in[k][j] = (j == 0) ? feed[k] : act_p1[k][(j == 0) ? 0 : j - 1];
                s_in[k][j] = (k == 0) ? '0 : psum_p1[(k == 0) ? 0 : k - 1][j];
                prod[k][j] = PROD_W'(a_in[k][j]) * PROD_W'(w_buf[k * N + j]);
            end
        end
    end

    // ---------------- stage p1: PE registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++)
                for (int j = 0; j < N; j++) begin
                    act_p1[k][j]  <= '0;
                    psum_p1[k][j] <= '0;
                end
        end else begin
            for (int k = 0; k < N; k++)
                for (int j = 0; j < N; j++) begin
                    act_p1[k][j]  <= a_in[k][j];
                    psum_p1[k][j] <= s_in[k][j] + ACC_W'(prod[k][j]);
                end
        end
    end

    // ---------------- stage p2: result capture ----------------
    // Column j's bottom register holds C[i][j] in compute cycle i+N+j.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < NN; e++)
                r_buf[e] <= '0;
        end else if (state == S_COMPUTE) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (int'(cnt) == i + N + j)
                        r_buf[i * N + j] <= acc_l
                            ? sat_acc(SUM_W'(r_buf[i * N + j]) + SUM_W'(psum_p1[N-1][j]))
                            : psum_p1[N-1][j];
        end
    end

endmodule
